subleq_loader: RTL and testbench
================================

Name: subleq_loader

Overview:
Boot-time program loader that sits directly upstream of the subleq core and its mem instance. It receives a byte stream (e.g. from a UART receiver) over a valid/ready handshake and assembles it into 64-bit words. It writes those words to consecutive memory addresses starting at 0, holding the core in reset until the image is complete. The top level muxes mem address/data/wren from the loader while oLoading is high, and from the core otherwise.

Parameters:
ADDR_WIDTH, 13, memory address width; matches the core's IP width.
WORD_WIDTH, 64, memory word width; must be a multiple of 8.
BYTES_PER_WORD, WORD_WIDTH/8, localparam; bytes per memory word.

Ports:
iClock  in  1  system clock; all state changes on the rising edge.
iReset  in  1  asynchronous, active-high reset.
iByte  in  8  incoming stream byte.
iByteValid  in  1  iByte is valid this cycle.
oByteReady  out  1  loader accepts iByte this cycle.
iReload  in  1  single-cycle pulse; restarts loading from the DONE state.
oMemAddress  out  ADDR_WIDTH  memory write address.
oMemData  out  WORD_WIDTH  memory write data.
oMemWren  out  1  memory write enable (one-cycle pulse).
oLoading  out  1  loader owns the memory port.
oCpuReset  out  1  drives the core's iReset.
oError  out  1  header count exceeded memory size (sticky until the next load).

Behaviour:
- Reset values: state=S_LEN_LO, oByteReady=0, oMemAddress=0, oMemData=0, oMemWren=0, oLoading=1, oCpuReset=1, oError=0; internal byte index=0, word counter=0.
- Byte transfer occurs on a rising edge with iByteValid && oByteReady. iByte is sampled only on a transfer.
- oByteReady=1 in S_LEN_LO, S_LEN_HI and S_DATA; 0 in all other states.
- Stream format: 2-byte little-endian header N (number of words), then N*BYTES_PER_WORD data bytes.
- Each word is little-endian: the first byte of the word goes to bits [7:0], the last to [WORD_WIDTH-1:WORD_WIDTH-8].

State machine:
- S_LEN_LO: on transfer, latch header low byte, go to S_LEN_HI.
- S_LEN_HI: on transfer, form N.
  - If N=0: go to S_DONE.
  - If N>2**ADDR_WIDTH: clamp N to 2**ADDR_WIDTH, set oError=1, go to S_DATA.
  - Otherwise: go to S_DATA.
- S_DATA: on each transfer, place the byte at the current index.
  - On the BYTES_PER_WORD-th byte, go to S_WRITE.
  - With no valid byte, wait indefinitely; there is no timeout.
- S_WRITE: exactly one cycle.
  - oMemWren=1, with oMemAddress = word counter and oMemData = assembled word (both registered).
  - Next edge: word counter +1, byte index cleared. If the written word was word N-1, go to S_DONE; else go to S_DATA.
- S_DONE: oLoading=0, oCpuReset=0, oMemWren=0.
  - iReload=1 goes to S_LEN_LO: oLoading=1, oCpuReset=1, oError=0, counters cleared.
  - iReload outside S_DONE is ignored.

Timing and boundary rules:
- Latency: the write pulse follows the word's last byte transfer by exactly one cycle. oCpuReset falls on the edge after the final write cycle.
- Word counter is ADDR_WIDTH+1 bits, so N=2**ADDR_WIDTH completes without wrap. Address 2**ADDR_WIDTH-1 is the final write.
- Bytes arriving after S_DONE are not accepted (ready=0). The upstream source holds them.
- Asynchronous reset mid-load returns to S_LEN_LO immediately with the core held in reset. A partial word is discarded; memory contents already written are left as is.
- oMemWren is never asserted outside S_WRITE, including during reset.

Decomposition:
- Shared package subleq_pkg: ADDR_WIDTH/WORD_WIDTH constants shared with the core and mem, and the loader state encoding (S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE; 3-bit).
- One natural sub-module: subleq_word_assembler, a byte index counter plus shift-in register. Inputs are byte and strobe; outputs are the word and a full flag.

Test Plan:
- Header 0x02,0x00, then bytes 0x01..0x10 with valid held high -> write of 0x0807060504030201 @0, then 0x100F0E0D0C0B0A09 @1. Each oMemWren pulse lasts 1 cycle; ready drops for each write cycle. oCpuReset=0 the cycle after the 2nd write.
- Header 0x00,0x00 -> no oMemWren; S_DONE reached; oLoading=0, oCpuReset=0, oError=0.
- Header 0x01,0x40 (N=16385) -> oError=1, count clamped to 8192. After 65536 bytes, the last write is @0x1FFF and the loader is done.
- 1 word sent with random valid gaps (valid low 0-5 cycles between bytes) -> same word written @0. Bytes are accepted only when valid&&ready.
- iReset asserted after 5 bytes of word 1 of a 3-word load, then a full 1-word reload -> immediate return to S_LEN_LO with oCpuReset=1; the new word is written @0.
- In S_DONE, iReload pulse followed by a 1-word image 0xFF×8 -> oCpuReset=1 the cycle after iReload; write of 0xFFFFFFFFFFFFFFFF @0; then done again.

Source files
------------

// File: rtl/subleq_pkg.sv
// Constants shared by the subleq core, its memory and the boot loader,
// plus the loader state encoding.
package subleq_pkg;
  localparam int ADDR_WIDTH     = 13;
  localparam int WORD_WIDTH     = 64;
  localparam int BYTES_PER_WORD = WORD_WIDTH / 8;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } loader_state_e;
endpackage

// File: rtl/subleq_loader_if.sv
// Byte-stream input and memory write port of the boot loader.
// master = stream source / memory side, slave = loader.
interface subleq_loader_if;
  import subleq_pkg::*;

  logic [7:0]            iByte;
  logic                  iByteValid;
  logic                  oByteReady;
  logic                  iReload;
  logic [ADDR_WIDTH-1:0] oMemAddress;
  logic [WORD_WIDTH-1:0] oMemData;
  logic                  oMemWren;
  logic                  oLoading;
  logic                  oCpuReset;
  logic                  oError;

  modport master (
    output iByte, iByteValid, iReload,
    input  oByteReady, oMemAddress, oMemData, oMemWren, oLoading, oCpuReset, oError
  );

  modport slave (
    input  iByte, iByteValid, iReload,
    output oByteReady, oMemAddress, oMemData, oMemWren, oLoading, oCpuReset, oError
  );
endinterface

// File: rtl/subleq_word_assembler.sv
// Packs strobed bytes little-endian into one word; o_full flags the strobe
// that completes a word, and the index wraps to 0 on that same edge.
module subleq_word_assembler
  import subleq_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_byte,
  input  logic                  i_strobe,
  input  logic                  i_clear,
  output logic [WORD_WIDTH-1:0] o_word,
  output logic                  o_full
);
  localparam int IW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic [IW-1:0]         r_idx;
  logic [WORD_WIDTH-1:0] r_word;

  assign o_full = i_strobe && (r_idx == IW'(BYTES_PER_WORD - 1));
  assign o_word = r_word;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
    end else if (i_strobe) begin
      r_word[{r_idx, 3'b000} +: 8] <= i_byte;
      r_idx <= o_full ? '0 : r_idx + IW'(1);
    end
  end
endmodule

// File: rtl/subleq_loader.sv
// Boot loader: 2-byte LE word count, then words written to mem from address 0.
// Write pulse 1 cycle after a word's last byte; ready low in S_WRITE/S_DONE.
module subleq_loader
  import subleq_pkg::*;
(
  input  logic            iClock,
  input  logic            iReset,
  subleq_loader_if.slave  bus
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  loader_state_e         r_state;
  logic                  r_ready;
  logic [7:0]            r_len_lo;
  logic [CW-1:0]         r_n;
  logic [CW-1:0]         r_word_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wren;
  logic                  r_loading;
  logic                  r_cpu_reset;
  logic                  r_error;

  logic                  w_xfer;
  logic                  w_full;
  logic [15:0]           w_len;
  logic [WORD_WIDTH-1:0] w_word;

  assign w_xfer = bus.iByteValid && r_ready;
  assign w_len  = {bus.iByte, r_len_lo};

  subleq_word_assembler u_asm (
    .i_clk    (iClock),
    .i_rst    (iReset),
    .i_byte   (bus.iByte),
    .i_strobe (w_xfer && (r_state == S_DATA)),
    .i_clear  ((r_state == S_DONE) && bus.iReload),
    .o_word   (w_word),
    .o_full   (w_full)
  );

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state     <= S_LEN_LO;
      r_ready     <= 1'b0;
      r_len_lo    <= '0;
      r_n         <= '0;
      r_word_cnt  <= '0;
      r_addr      <= '0;
      r_wren      <= 1'b0;
      r_loading   <= 1'b1;
      r_cpu_reset <= 1'b1;
      r_error     <= 1'b0;
    end else begin
      r_wren <= 1'b0;
      case (r_state)
        S_LEN_LO: begin
          r_ready <= 1'b1;
          if (w_xfer) begin
            r_len_lo <= bus.iByte;
            r_state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            if (w_len == 16'd0) begin
              r_state     <= S_DONE;
              r_ready     <= 1'b0;
              r_loading   <= 1'b0;
              r_cpu_reset <= 1'b0;
            end else if (32'(w_len) > (32'd1 << ADDR_WIDTH)) begin
              r_n     <= MAX_WORDS;
              r_error <= 1'b1;
              r_state <= S_DATA;
            end else begin
              r_n     <= CW'(w_len);
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_full) begin
            r_state <= S_WRITE;
            r_ready <= 1'b0;
            r_wren  <= 1'b1;
            r_addr  <= r_word_cnt[ADDR_WIDTH-1:0];
          end
        end
        S_WRITE: begin
          r_word_cnt <= r_word_cnt + CW'(1);
          if ((r_word_cnt + CW'(1)) == r_n) begin
            r_state     <= S_DONE;
            r_loading   <= 1'b0;
            r_cpu_reset <= 1'b0;
          end else begin
            r_state <= S_DATA;
            r_ready <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.iReload) begin
            r_state     <= S_LEN_LO;
            r_ready     <= 1'b1;
            r_loading   <= 1'b1;
            r_cpu_reset <= 1'b1;
            r_error     <= 1'b0;
            r_word_cnt  <= '0;
          end
        end
        default: r_state <= S_LEN_LO;
      endcase
    end
  end

  assign bus.oByteReady  = r_ready;
  assign bus.oMemAddress = r_addr;
  assign bus.oMemData    = w_word;
  assign bus.oMemWren    = r_wren;
  assign bus.oLoading    = r_loading;
  assign bus.oCpuReset   = r_cpu_reset;
  assign bus.oError      = r_error;
endmodule

// File: tb/tb_subleq_loader.sv
// Directed bench for subleq_loader: inputs driven 1 time unit after the rising
// edge, a negedge monitor records every memory write and handshake event.
module tb_subleq_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  subleq_loader_if bus ();
  subleq_loader dut (.iClock(clk), .iReset(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  int cyc = 0, xfers = 0, wr_cnt = 0, multi = 0, rdy_wr = 0, lat_bad = 0;
  int last_wr_cyc = -10, fall_cyc = -1;
  logic prev_xfer = 1'b0, prev_wren = 1'b0, prev_cpu = 1'b1;
  logic [12:0] wr_addr_q[$];
  logic [63:0] wr_data_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.iByteValid && bus.oByteReady) xfers <= xfers + 1;
    if (bus.oMemWren) begin
      wr_cnt <= wr_cnt + 1;
      wr_addr_q.push_back(bus.oMemAddress);
      wr_data_q.push_back(bus.oMemData);
      last_wr_cyc <= cyc;
      if (prev_wren) multi <= multi + 1;
      if (bus.oByteReady) rdy_wr <= rdy_wr + 1;
      if (!prev_xfer) lat_bad <= lat_bad + 1;
    end
    if (prev_cpu && !bus.oCpuReset) fall_cyc <= cyc;
    prev_xfer <= bus.iByteValid && bus.oByteReady;
    prev_wren <= bus.oMemWren;
    prev_cpu  <= bus.oCpuReset;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entry and exit are both 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    bit sent = 1'b0;
    bus.iByte      = b;
    bus.iByteValid = 1'b1;
    for (int k = 0; k < 20 && !sent; k++) begin
      @(negedge clk);
      if (bus.oByteReady) begin
        @(posedge clk);
        #1;
        sent = 1'b1;
      end
    end
    if (!sent) chk("send_ready_timeout", {63'd0, bus.oByteReady}, 64'd1);
  endtask

  task automatic idle(input int n);
    bus.iByteValid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int budget);
    bus.iByteValid = 1'b0;
    for (int k = 0; k < budget && bus.oLoading; k++) begin
      @(negedge clk);
    end
    chk("done_reached", {63'd0, bus.oLoading}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic reload();
    bus.iReload = 1'b1;
    @(posedge clk);
    #1;
    bus.iReload = 1'b0;
    @(negedge clk);
    chk("reload_cpu_reset", {63'd0, bus.oCpuReset}, 64'd1);
    chk("reload_error_clr", {63'd0, bus.oError}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int xf0;
    int gaps[8] = '{0, 3, 5, 1, 2, 4, 0, 5};

    bus.iByte = 8'h00;
    bus.iByteValid = 1'b0;
    bus.iReload = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",   {63'd0, bus.oByteReady}, 64'd0);
    chk("rst_addr",    {51'd0, bus.oMemAddress}, 64'd0);
    chk("rst_data",    bus.oMemData, 64'd0);
    chk("rst_wren",    {63'd0, bus.oMemWren}, 64'd0);
    chk("rst_loading", {63'd0, bus.oLoading}, 64'd1);
    chk("rst_cpu",     {63'd0, bus.oCpuReset}, 64'd1);
    chk("rst_error",   {63'd0, bus.oError}, 64'd0);
    rst = 1'b0;

    // Two words, valid held high
    base = wr_cnt;
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    wait_done(50);
    chk("a_wr_count", 64'(wr_cnt - base), 64'd2);
    chk("a_addr0", {51'd0, wr_addr_q[base]}, 64'd0);
    chk("a_data0", wr_data_q[base], 64'h0807060504030201);
    chk("a_addr1", {51'd0, wr_addr_q[base+1]}, 64'd1);
    chk("a_data1", wr_data_q[base+1], 64'h100F0E0D0C0B0A09);
    chk("a_cpu_fall_timing", 64'(fall_cyc), 64'(last_wr_cyc + 1));
    chk("a_cpu_reset", {63'd0, bus.oCpuReset}, 64'd0);
    chk("a_error", {63'd0, bus.oError}, 64'd0);

    // Bytes offered after completion must be held off
    xf0 = xfers;
    bus.iByte = 8'h55;
    bus.iByteValid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.iByteValid = 1'b0;
    chk("done_no_accept", 64'(xfers - xf0), 64'd0);
    chk("done_ready", {63'd0, bus.oByteReady}, 64'd0);

    // Empty image
    reload();
    base = wr_cnt;
    send_byte(8'h00);
    send_byte(8'h00);
    wait_done(10);
    chk("b_no_writes", 64'(wr_cnt - base), 64'd0);
    chk("b_cpu_reset", {63'd0, bus.oCpuReset}, 64'd0);
    chk("b_error", {63'd0, bus.oError}, 64'd0);

    // Oversized header 0x4001 clamps to 8192 words
    reload();
    base = wr_cnt;
    send_byte(8'h01);
    send_byte(8'h40);
    chk("c_error_set", {63'd0, bus.oError}, 64'd1);
    for (int i = 0; i < 65536; i++) send_byte(8'(i));
    wait_done(50);
    chk("c_wr_count", 64'(wr_cnt - base), 64'd8192);
    chk("c_last_addr", {51'd0, wr_addr_q[wr_cnt-1]}, 64'h1FFF);
    chk("c_last_data", wr_data_q[wr_cnt-1], 64'hFFFEFDFCFBFAF9F8);
    chk("c_error_sticky", {63'd0, bus.oError}, 64'd1);

    // One word with valid gaps
    reload();
    base = wr_cnt;
    xf0 = xfers;
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'hA1 + 8'(i));
      if (gaps[i] > 0) idle(gaps[i]);
    end
    wait_done(50);
    chk("d_xfers", 64'(xfers - xf0), 64'd10);
    chk("d_wr_count", 64'(wr_cnt - base), 64'd1);
    chk("d_addr", {51'd0, wr_addr_q[base]}, 64'd0);
    chk("d_data", wr_data_q[base], 64'hA8A7A6A5A4A3A2A1);

    // Reset in the middle of word 1 of a 3-word load
    reload();
    base = wr_cnt;
    send_byte(8'h03);
    send_byte(8'h00);
    for (int i = 0; i < 13; i++) send_byte(8'h11 + 8'(i));
    bus.iByteValid = 1'b0;
    rst = 1'b1;
    #1;
    chk("e_rst_cpu", {63'd0, bus.oCpuReset}, 64'd1);
    chk("e_rst_loading", {63'd0, bus.oLoading}, 64'd1);
    chk("e_rst_ready", {63'd0, bus.oByteReady}, 64'd0);
    chk("e_rst_wren", {63'd0, bus.oMemWren}, 64'd0);
    chk("e_partial_writes", 64'(wr_cnt - base), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = wr_cnt;
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 8; i++) send_byte(8'h21 + 8'(i));
    wait_done(50);
    chk("e_wr_count", 64'(wr_cnt - base), 64'd1);
    chk("e_addr", {51'd0, wr_addr_q[base]}, 64'd0);
    chk("e_data", wr_data_q[base], 64'h2827262524232221);

    // Reload with an all-ones word
    reload();
    base = wr_cnt;
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 8; i++) send_byte(8'hFF);
    wait_done(50);
    chk("f_wr_count", 64'(wr_cnt - base), 64'd1);
    chk("f_addr", {51'd0, wr_addr_q[base]}, 64'd0);
    chk("f_data", wr_data_q[base], 64'hFFFFFFFFFFFFFFFF);
    chk("f_cpu_reset", {63'd0, bus.oCpuReset}, 64'd0);

    chk("wren_single_cycle", 64'(multi), 64'd0);
    chk("ready_low_in_write", 64'(rdy_wr), 64'd0);
    chk("write_latency", 64'(lat_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
